// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver that assembles NUM_WORDS LSB-first packets into one frame.
// Optional partial-frame idle timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_frame #(
    parameter  int CLOCKS_PER_PULSE = 4,
    parameter  int BITS_PER_WORD    = 8,
    parameter  int W_OUT            = 24,
    parameter  int TIMEOUT_PULSES   = 32,
    localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rx,
    output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  m_data,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic                                     frame_err,
    output logic                                     overrun
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam int BW = $clog2(BITS_PER_WORD + 1);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(BITS_PER_WORD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                                  r_state;
    logic                                    r_rxMeta;
    logic                                    r_rxSync;
    logic                                    r_rxPrev;
    logic [CW-1:0]                           r_clkCnt;
    logic [BW-1:0]                           r_bitCnt;
    logic [IW-1:0]                           r_wordIdx;
    logic [BITS_PER_WORD-1:0]                r_shreg;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] r_words;
    logic                                    r_complete;
    logic                                    w_fall;
    logic                                    w_timeout;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
        end
    end

    assign w_fall = r_rxPrev & ~r_rxSync;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_PULSES + 1);

    logic [CW-1:0] r_toClk;
    logic [TW-1:0] r_toPulses;

    assign w_timeout = (r_toPulses == TW'(TIMEOUT_PULSES));

    // Bit periods spent idle with a partial frame held; any falling edge restarts the count.
    always_ff @(posedge clk) begin
        if (rst || w_fall || w_timeout || r_state != S_IDLE || r_wordIdx == '0) begin
            r_toClk    <= '0;
            r_toPulses <= '0;
        end else if (r_toClk == BIT_LAST) begin
            r_toClk    <= '0;
            r_toPulses <= r_toPulses + 1'b1;
        end else begin
            r_toClk <= r_toClk + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Packet FSM; a good stop bit stores the word, the last word raises r_complete for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clkCnt   <= '0;
            r_bitCnt   <= '0;
            r_wordIdx  <= '0;
            r_shreg    <= '0;
            r_words    <= '0;
            r_complete <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_timeout) begin
                        r_wordIdx <= '0;
                    end
                    if (w_fall) begin
                        r_state  <= S_START;
                        r_clkCnt <= '0;
                    end
                end
                S_START: begin
                    if (r_clkCnt == HALF_LAST) begin
                        r_clkCnt <= '0;
                        r_bitCnt <= '0;
                        r_state  <= r_rxSync ? S_IDLE : S_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clkCnt == BIT_LAST) begin
                        r_clkCnt <= '0;
                        r_shreg  <= {r_rxSync, r_shreg[BITS_PER_WORD-1:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == BITS_LAST) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_clkCnt == BIT_LAST) begin
                        r_clkCnt <= '0;
                        r_state  <= S_IDLE;
                        if (!r_rxSync) begin
                            frame_err <= 1'b1;
                            r_wordIdx <= '0;
                        end else begin
                            r_words[r_wordIdx] <= r_shreg;
                            if (r_wordIdx == IDX_LAST) begin
                                r_wordIdx  <= '0;
                                r_complete <= 1'b1;
                            end else begin
                                r_wordIdx <= r_wordIdx + 1'b1;
                            end
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output stage: a completed frame loads unless the previous one is stalled, which is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (r_complete) begin
                if (m_valid && !m_ready) begin
                    overrun <= 1'b1;
                end else begin
                    m_data  <= r_words;
                    m_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame; expected frames are queued as they are sent
// and popped on each handshake. Define UART_RX_TIMEOUT_EN to also exercise the idle timeout.
module tb_uart_rx_frame;

    localparam int CPP     = 4;
    localparam int BPW     = 8;
    localparam int WOUT    = 24;
    localparam int NW      = WOUT / BPW;
    localparam int LATENCY = 2 + CPP / 2 + (BPW + 1) * CPP + 1;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         rx = 1'b1;
    logic [NW-1:0][BPW-1:0]       m_data;
    logic                         m_valid;
    logic                         m_ready = 1'b0;
    logic                         frame_err;
    logic                         overrun;

    logic [WOUT-1:0] sbQueue[$];
    int compareCount  = 0;
    int mismatchCount = 0;

    uart_rx_frame #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .W_OUT           (WOUT),
        .TIMEOUT_PULSES  (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every handshake pops the oldest expected frame and compares it with m_data.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("extra_frame", 32'(sbQueue.size()), 32'd1);
            end else begin
                checkOutput("frame", 32'(m_data), 32'(sbQueue.pop_front()));
            end
        end
    end

    task automatic sendBit(input logic b);
        rx = b;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    task automatic idleBits(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b1);
    endtask

    task automatic applyStimulus(input logic [BPW-1:0] data, input int stops, input logic firstStop);
        sendBit(1'b0);
        for (int i = 0; i < BPW; i++) sendBit(data[i]);
        sendBit(firstStop);
        for (int i = 1; i < stops; i++) sendBit(1'b1);
    endtask

    task automatic sendFrame(input logic [WOUT-1:0] f, input int stops);
        for (int w = 0; w < NW; w++) applyStimulus(f[w*BPW +: BPW], stops, 1'b1);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        idleBits(2);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        applyReset();

        // Clean frame with four stop bits per packet, plus the start-to-valid latency of the last word.
        m_ready = 1'b1;
        sbQueue.push_back(24'h332211);
        applyStimulus(8'h11, 4, 1'b1);
        applyStimulus(8'h22, 4, 1'b1);
        fork
            applyStimulus(8'h33, 4, 1'b1);
            begin
                int n = 0;
                while (n < 200 && !m_valid) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checkOutput("latency", 32'(n - 1), 32'(LATENCY));
            end
        join
        idleBits(2);
        checkOutput("t1_frame_err", 32'(frame_err), 32'd0);
        checkOutput("t1_overrun", 32'(overrun), 32'd0);
        checkOutput("t1_drained", 32'(sbQueue.size()), 32'd0);

        // One-clock glitch must not start a word; the next frame proves word_idx stayed at 0.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        idleBits(3);
        checkOutput("t2_m_valid", 32'(m_valid), 32'd0);
        sbQueue.push_back(24'hC3B2A1);
        sendFrame(24'hC3B2A1, 2);
        idleBits(2);
        checkOutput("t2_frame_err", 32'(frame_err), 32'd0);

        // Bad stop bit on word 1 discards the partial frame; the following clean frame arrives intact.
        applyStimulus(8'h77, 2, 1'b1);
        applyStimulus(8'h66, 2, 1'b0);
        idleBits(2);
        checkOutput("t3_frame_err", 32'(frame_err), 32'd1);
        checkOutput("t3_m_valid", 32'(m_valid), 32'd0);
        sbQueue.push_back(24'hFF5AA5);
        sendFrame(24'hFF5AA5, 2);
        idleBits(2);
        checkOutput("t3_drained", 32'(sbQueue.size()), 32'd0);
        applyReset();

        // Stalled consumer: the second frame is dropped and overrun sets.
        m_ready = 1'b0;
        sbQueue.push_back(24'h030201);
        sendFrame(24'h030201, 2);
        sendFrame(24'h060504, 2);
        idleBits(2);
        checkOutput("t4_hold_data", 32'(m_data), 32'h030201);
        checkOutput("t4_m_valid", 32'(m_valid), 32'd1);
        checkOutput("t4_overrun", 32'(overrun), 32'd1);
        m_ready = 1'b1;
        idleBits(2);
        checkOutput("t4_valid_low", 32'(m_valid), 32'd0);
        checkOutput("t4_drained", 32'(sbQueue.size()), 32'd0);
        applyReset();

        // Handshake lands exactly on frame 2 completion: both frames transfer in order, no overrun.
        m_ready = 1'b0;
        sbQueue.push_back(24'h0C0B0A);
        sendFrame(24'h0C0B0A, 2);
        sbQueue.push_back(24'h0F0E0D);
        applyStimulus(8'h0D, 2, 1'b1);
        applyStimulus(8'h0E, 2, 1'b1);
        fork
            applyStimulus(8'h0F, 2, 1'b1);
            begin
                repeat (LATENCY) @(posedge clk);
                #1;
                m_ready = 1'b1;
                @(posedge clk);
                #1;
                m_ready = 1'b0;
            end
        join
        idleBits(1);
        checkOutput("t5_m_valid", 32'(m_valid), 32'd1);
        checkOutput("t5_second_data", 32'(m_data), 32'h0F0E0D);
        m_ready = 1'b1;
        idleBits(2);
        checkOutput("t5_overrun", 32'(overrun), 32'd0);
        checkOutput("t5_drained", 32'(sbQueue.size()), 32'd0);

        // Reset in the middle of word 1 throws away word 0.
        applyStimulus(8'hEE, 2, 1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        applyReset();
        sbQueue.push_back(24'h030201);
        sendFrame(24'h030201, 2);
        idleBits(2);
        checkOutput("t6_drained", 32'(sbQueue.size()), 32'd0);

`ifdef UART_RX_TIMEOUT_EN
        // A lone word followed by a long idle gap is discarded by the timeout.
        applyStimulus(8'h99, 1, 1'b1);
        idleBits(40);
        sbQueue.push_back(24'h0C0B0A);
        sendFrame(24'h0C0B0A, 2);
        idleBits(2);
        checkOutput("t6_timeout_drained", 32'(sbQueue.size()), 32'd0);
`endif

        checkOutput("final_frame_err", 32'(frame_err), 32'd0);
        checkOutput("final_overrun", 32'(overrun), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
